// File: rtl/pwm_io_pkg.sv
// Shared constants and frame-state encoding for the SPI register interface
// that feeds the PWM duty/enable registers.
package pwm_io_pkg;
   localparam int         DEF_NUM_CH   = 4;
   localparam int         DEF_DUTY_W   = 8;
   localparam logic [7:0] DEF_ID_VALUE = 8'hA5;

   localparam logic [2:0] ADDR_EN = 3'd4;
   localparam logic [2:0] ADDR_ID = 3'd5;

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} frame_st_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one SPI pin plus a third flop for edge detection.
// RST_VAL is the pin's idle level so reset never produces a false edge.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [2:0] sr;

   always_ff @(posedge clk or posedge rst)
      if (rst) sr <= {3{RST_VAL}};
      else     sr <= {sr[1:0], din};

   assign q    = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_pwm_reg_if.sv
// SPI mode-0 slave giving register access to the PWM duty and enable
// registers; all SPI pins are oversampled in the CLK domain.
module spi_pwm_reg_if
   import pwm_io_pkg::*;
#(
   parameter int         NUM_CH   = DEF_NUM_CH,
   parameter int         DUTY_W   = DEF_DUTY_W,
   parameter logic [7:0] ID_VALUE = DEF_ID_VALUE
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     CS,
   input  logic                     SCLK,
   input  logic                     MOSI,
   output logic                     MISO,
   output logic [NUM_CH*DUTY_W-1:0] duty,
   output logic [NUM_CH-1:0]        en_mask,
   output logic                     update,
   output logic                     frame_err
);
   localparam int         STAGES    = 1;
   localparam logic [2:0] SYNC_IDLE = 3'b001;   // {mosi, sclk, cs}

   logic [2:0] sync_in, sync_q, sync_rise, sync_fall;
   assign sync_in = {MOSI, SCLK, CS};

   for (genvar i = 0; i < 3; i++) begin : g_sync
      spi_sync_edge #(.RST_VAL(SYNC_IDLE[i])) u_sync (
         .clk (CLK),
         .rst (RST),
         .din (sync_in[i]),
         .q   (sync_q[i]),
         .rise(sync_rise[i]),
         .fall(sync_fall[i])
      );
   end

   logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
   assign cs_rise   = sync_rise[0];
   assign cs_fall   = sync_fall[0];
   assign sclk_rise = sync_rise[1];
   assign sclk_fall = sync_fall[1];
   assign mosi_s    = sync_q[2];

   logic unused_sync;
   assign unused_sync = ^{sync_q[1:0], sync_rise[2], sync_fall[2]};

   frame_st_e                        st;
   logic [2:0]                       bitcnt, addr, wr_addr, rd_addr;
   logic [6:0]                       shreg;
   logic [7:0]                       byte_in, tx_sr, wr_data, rd_byte;
   logic                             rw, tx_skip, wr_ok;
   logic [STAGES:0]                  vld_pipe;
   logic [NUM_CH-1:0][DUTY_W-1:0]    duty_r;

   assign duty    = duty_r;
   assign byte_in = {shreg, mosi_s};
   assign wr_ok   = (int'(addr) < NUM_CH) || (addr == ADDR_EN);

   // Read source: the command's address on the command byte, else the next burst address.
   always_comb begin
      rd_addr = (st == ST_CMD) ? byte_in[2:0] : addr + 3'd1;
      rd_byte = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (rd_addr == 3'(k)) rd_byte = 8'(duty_r[k]);
      if (rd_addr == ADDR_EN) rd_byte = 8'(en_mask);
      if (rd_addr == ADDR_ID) rd_byte = ID_VALUE;
   end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         st        <= ST_IDLE;
         bitcnt    <= '0;
         shreg     <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         tx_sr     <= '0;
         tx_skip   <= 1'b0;
         MISO      <= 1'b0;
         frame_err <= 1'b0;
         vld_pipe  <= '0;
         wr_data   <= '0;
         wr_addr   <= '0;
      end else begin
         frame_err <= 1'b0;
         vld_pipe  <= {vld_pipe[STAGES-1:0], 1'b0};

         if (st == ST_IDLE) begin
            if (cs_fall) begin
               st      <= ST_CMD;
               bitcnt  <= '0;
               tx_sr   <= '0;
               tx_skip <= 1'b0;
               MISO    <= 1'b0;
            end
         end else if (sclk_rise) begin
            shreg  <= byte_in[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
               if (st == ST_CMD) begin
                  rw   <= byte_in[7];
                  addr <= byte_in[2:0];
                  st   <= ST_DATA;
               end else begin
                  if (rw && wr_ok) begin
                     vld_pipe[0] <= 1'b1;
                     wr_data     <= byte_in;
                     wr_addr     <= addr;
                  end
                  addr <= addr + 3'd1;
               end
               // Read frames load the next byte so its MSB is on MISO before the next rise.
               if ((st == ST_CMD && !byte_in[7]) || (st == ST_DATA && !rw)) begin
                  tx_sr   <= rd_byte;
                  MISO    <= rd_byte[7];
                  tx_skip <= 1'b1;
               end
            end
         end else if (sclk_fall && st == ST_DATA && !rw) begin
            if (tx_skip) tx_skip <= 1'b0;
            else begin
               tx_sr <= {tx_sr[6:0], 1'b0};
               MISO  <= tx_sr[6];
            end
         end

         // A byte completing in the same cycle as CS rise still counts as whole.
         if (st != ST_IDLE && cs_rise) begin
            st        <= ST_IDLE;
            bitcnt    <= '0;
            tx_sr     <= '0;
            tx_skip   <= 1'b0;
            MISO      <= 1'b0;
            frame_err <= (bitcnt != 3'd0) && !(sclk_rise && bitcnt == 3'd7);
         end
      end

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         duty_r  <= '0;
         en_mask <= '0;
         update  <= 1'b0;
      end else begin
         update <= vld_pipe[STAGES];
         if (vld_pipe[STAGES]) begin
            if (wr_addr == ADDR_EN) en_mask <= wr_data[NUM_CH-1:0];
            for (int k = 0; k < NUM_CH; k++)
               if (wr_addr == 3'(k)) duty_r[k] <= DUTY_W'(wr_data);
         end
      end
endmodule

// File: tb/tb_spi_pwm_reg_if.sv
// Directed bench: table of SPI frames with expected register/MISO results,
// then hand sequences for commit latency, aborted frames, CS/SCLK coincidence and reset.
module tb_spi_pwm_reg_if;
   logic        CLK = 1'b0, RST = 1'b1, CS = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
   logic        MISO, update, frame_err;
   logic [31:0] duty;
   logic [3:0]  en_mask;

   spi_pwm_reg_if dut (
      .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .duty(duty), .en_mask(en_mask), .update(update), .frame_err(frame_err)
   );

   always #5 CLK = ~CLK;

   int  checks = 0, errors = 0;
   int  upd_cnt = 0, ferr_cnt = 0;
   time upd_t = 0, rise8_t = 0;

   always @(negedge CLK) begin
      if (update) begin upd_cnt++; upd_t = $time; end
      if (frame_err) ferr_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Shifts n bits of v (MSB first); bit 8 optionally raises CS together with SCLK.
   task automatic spi_bits(input logic [7:0] v, input int n, input bit cs_last,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         MOSI = v[7-i];
         #80;
         rx[7-i] = MISO;
         SCLK = 1'b1;
         if (i == 7) rise8_t = $time;
         if (cs_last && i == n-1) CS = 1'b1;
         #80;
         SCLK = 1'b0;
      end
   endtask

   // First byte of a frame is tx[47:40].
   task automatic run_frame(input int n, input logic [47:0] tx, output logic [47:0] rx);
      logic [7:0] r;
      rx = '0;
      @(negedge CLK);
      CS = 1'b0;
      #80;
      for (int k = 0; k < n; k++) begin
         spi_bits(tx[47-8*k -: 8], 8, 1'b0, r);
         rx[47-8*k -: 8] = r;
      end
      #80;
      CS = 1'b1;
      #160;
   endtask

   typedef struct {
      int          n;
      logic [47:0] tx;
      logic [47:0] rx;
      logic [31:0] duty;
      logic [3:0]  en;
      int          upd;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [47:0] rx;
      logic [7:0]  r;
      int          u0, f0;

      vecs[0] = '{2, 48'h81_7F_00_00_00_00, 48'h00_00_00_00_00_00, 32'h0000_7F00, 4'h0, 1};
      vecs[1] = '{6, 48'h80_11_22_33_44_0F, 48'h00_00_00_00_00_00, 32'h4433_2211, 4'hF, 5};
      vecs[2] = '{2, 48'h05_00_00_00_00_00, 48'h00_A5_00_00_00_00, 32'h4433_2211, 4'hF, 0};
      vecs[3] = '{4, 48'h03_00_00_00_00_00, 48'h00_44_0F_A5_00_00, 32'h4433_2211, 4'hF, 0};
      vecs[4] = '{4, 48'h85_11_22_33_00_00, 48'h00_00_00_00_00_00, 32'h4433_2211, 4'hF, 0};
      vecs[5] = '{4, 48'h06_00_00_00_00_00, 48'h00_00_00_11_00_00, 32'h4433_2211, 4'hF, 0};
      vecs[6] = '{2, 48'h84_03_00_00_00_00, 48'h00_00_00_00_00_00, 32'h4433_2211, 4'h3, 1};
      vecs[7] = '{2, 48'h84_FC_00_00_00_00, 48'h00_00_00_00_00_00, 32'h4433_2211, 4'hC, 1};
      vecs[8] = '{3, 48'h87_55_06_00_00_00, 48'h00_00_00_00_00_00, 32'h4433_2206, 4'hC, 1};
      vecs[9] = '{5, 48'h00_00_00_00_00_00, 48'h00_06_22_33_44_00, 32'h4433_2206, 4'hC, 0};

      // Reset state
      #23;
      chk("reset duty", duty, 32'h0);
      chk("reset en_mask", {28'h0, en_mask}, 32'h0);
      chk("reset misc", {29'h0, MISO, update, frame_err}, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      #100;

      for (int v = 0; v < 10; v++) begin
         u0 = upd_cnt; f0 = ferr_cnt;
         run_frame(vecs[v].n, vecs[v].tx, rx);
         chk($sformatf("v%0d duty", v), duty, vecs[v].duty);
         chk($sformatf("v%0d en_mask", v), {28'h0, en_mask}, {28'h0, vecs[v].en});
         chk($sformatf("v%0d update count", v), upd_cnt - u0, vecs[v].upd);
         chk($sformatf("v%0d frame_err count", v), ferr_cnt - f0, 0);
         for (int k = 0; k < vecs[v].n; k++)
            chk($sformatf("v%0d miso byte %0d", v, k), {24'h0, rx[47-8*k -: 8]},
                {24'h0, vecs[v].rx[47-8*k -: 8]});
      end

      // Commit lands on the 5th falling CLK edge after SCLK goes high on bit 8
      u0 = upd_cnt;
      run_frame(2, 48'h81_7F_00_00_00_00, rx);
      chk("latency duty", duty, 32'h4433_7F06);
      chk("latency update count", upd_cnt - u0, 1);
      chk("latency ns", 32'(upd_t - rise8_t), 32'd50);

      // Aborted byte: 0x82 then 5 bits, CS high
      u0 = upd_cnt; f0 = ferr_cnt;
      @(negedge CLK);
      CS = 1'b0;
      #80;
      spi_bits(8'h82, 8, 1'b0, r);
      spi_bits(8'hF0, 5, 1'b0, r);
      #80;
      CS = 1'b1;
      #160;
      chk("abort frame_err count", ferr_cnt - f0, 1);
      chk("abort update count", upd_cnt - u0, 0);
      chk("abort duty", duty, 32'h4433_7F06);
      run_frame(2, 48'h82_99_00_00_00_00, rx);
      chk("after abort duty", duty, 32'h4499_7F06);
      chk("after abort frame_err count", ferr_cnt - f0, 1);

      // CS rises together with the 8th SCLK rise of a data byte
      u0 = upd_cnt; f0 = ferr_cnt;
      @(negedge CLK);
      CS = 1'b0;
      #80;
      spi_bits(8'h83, 8, 1'b0, r);
      spi_bits(8'hAB, 8, 1'b1, r);
      #240;
      chk("cs+rise duty", duty, 32'hAB99_7F06);
      chk("cs+rise update count", upd_cnt - u0, 1);
      chk("cs+rise frame_err count", ferr_cnt - f0, 0);

      // Reset mid-byte clears outputs without a clock edge
      @(negedge CLK);
      CS = 1'b0;
      #80;
      spi_bits(8'h80, 8, 1'b0, r);
      spi_bits(8'hAA, 3, 1'b0, r);
      #2;
      RST = 1'b1;
      #1;
      chk("async reset duty", duty, 32'h0);
      chk("async reset en_mask", {28'h0, en_mask}, 32'h0);
      chk("async reset misc", {29'h0, MISO, update, frame_err}, 32'h0);
      #17;
      CS = 1'b1;
      SCLK = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      #100;
      u0 = upd_cnt;
      run_frame(2, 48'h80_55_00_00_00_00, rx);
      chk("post reset duty", duty, 32'h0000_0055);
      chk("post reset en_mask", {28'h0, en_mask}, 32'h0);
      chk("post reset update count", upd_cnt - u0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
